// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and sizing helpers for the button counter
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } deb_state_t;

  // Width of a counter that must hold values 0..n
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer, debounce FSM and auto-repeat for one button
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int TW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  deb_state_t    state, state_d;
  logic          sync1, sync2;
  logic [CW-1:0] stab, stab_d;
  logic [TW-1:0] rpt, rpt_d;
  logic          rpt_on, rpt_on_d;
  logic          pulse_d;
  logic          stable_done;
  logic          rpt_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      state  <= IDLE;
      stab   <= '0;
      rpt    <= '0;
      rpt_on <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      state  <= state_d;
      stab   <= stab_d;
      rpt    <= rpt_d;
      rpt_on <= rpt_on_d;
      pulse  <= pulse_d;
    end
  end

  // stab counts stable samples already seen; the current one completes the run
  assign stable_done = (32'(stab) + 32'd1 >= DEBOUNCE_CYCLES);
  assign rpt_hit     = (32'(rpt) + 32'd1 == (rpt_on ? REPEAT_PERIOD : REPEAT_DELAY));
  assign level       = (state == HELD) || (state == REL_CHK);

  always_comb begin
    state_d  = state;
    stab_d   = '0;
    rpt_d    = rpt;
    rpt_on_d = rpt_on;
    pulse_d  = 1'b0;
    case (state)
      IDLE: begin
        rpt_d    = '0;
        rpt_on_d = 1'b0;
        if (sync2) begin
          if (stable_done) begin
            state_d = HELD;
            pulse_d = 1'b1;
          end else begin
            state_d = PRESS_CHK;
            stab_d  = CW'(1);
          end
        end
      end
      PRESS_CHK: begin
        if (!sync2) begin
          state_d = IDLE;
        end else if (stable_done) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end else begin
          stab_d = stab + 1'b1;
        end
      end
      HELD: begin
        if (!sync2) begin
          if (stable_done) begin
            state_d = IDLE;
          end else begin
            state_d = REL_CHK;
            stab_d  = CW'(1);
          end
        end else if (REPEAT_DELAY > 0) begin
          // repeat timer only advances while solidly held, so release bounce pauses it
          if (rpt_hit) begin
            pulse_d  = 1'b1;
            rpt_d    = '0;
            rpt_on_d = 1'b1;
          end else begin
            rpt_d = rpt + 1'b1;
          end
        end
      end
      REL_CHK: begin
        if (sync2) begin
          state_d = HELD;
        end else if (stable_done) begin
          state_d = IDLE;
        end else begin
          stab_d = stab + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/updown_button_counter.sv
// rtl/updown_button_counter.sv - up/down/clear button counter with wrap or saturate
module updown_button_counter
  import button_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int WRAP            = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] count,
  output logic             up_evt,
  output logic             down_evt,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic       up_p, down_p, clr_p;
  logic [2:0] unused_levels;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .clk(clk), .rst(rst), .raw(btn_up), .pulse(up_p), .level(unused_levels[0])
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (
    .clk(clk), .rst(rst), .raw(btn_down), .pulse(down_p), .level(unused_levels[1])
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (0),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_clr (
    .clk(clk), .rst(rst), .raw(btn_clr), .pulse(clr_p), .level(unused_levels[2])
  );

  // Clear dominates; simultaneous up and down cancel without an event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      up_evt   <= 1'b0;
      down_evt <= 1'b0;
    end else begin
      up_evt   <= 1'b0;
      down_evt <= 1'b0;
      if (clr_p) begin
        count <= '0;
      end else if (up_p && !down_p) begin
        if (WRAP != 0 || count != MAX_COUNT) begin
          count  <= count + 1'b1;
          up_evt <= 1'b1;
        end
      end else if (down_p && !up_p) begin
        if (WRAP != 0 || count != '0) begin
          count    <= count - 1'b1;
          down_evt <= 1'b1;
        end
      end
    end
  end

  assign at_max = (count == MAX_COUNT);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_button_counter.sv
// tb/tb_updown_button_counter.sv - self-checking bench for updown_button_counter
module tb_updown_button_counter;

  localparam int W    = 4;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_clr = 1'b0;

  logic [W-1:0] count_w, count_s, count_r;
  logic up_evt_w, down_evt_w, at_max_w, at_min_w;
  logic up_evt_s, down_evt_s, at_max_s, at_min_s;
  logic up_evt_r, down_evt_r, at_max_r, at_min_r;

  always #5 clk = ~clk;

  updown_button_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0),
                          .REPEAT_PERIOD(8), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .count(count_w), .up_evt(up_evt_w), .down_evt(down_evt_w), .at_max(at_max_w), .at_min(at_min_w));

  updown_button_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0),
                          .REPEAT_PERIOD(8), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .count(count_s), .up_evt(up_evt_s), .down_evt(down_evt_s), .at_max(at_max_s), .at_min(at_min_s));

  updown_button_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
                          .REPEAT_PERIOD(RP), .WRAP(1)) dut_r (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .count(count_r), .up_evt(up_evt_r), .down_evt(down_evt_r), .at_max(at_max_r), .at_min(at_min_r));

  int checks = 0, errors = 0, cyc = 0;
  int nup_w = 0, ndn_w = 0, nup_s = 0, ndn_s = 0, nup_r = 0;

  // Reference: a level flips once the synchronised input (raw two edges ago)
  // has disagreed with it for D consecutive edges; rising flips are presses.
  bit sh0[3], sh1[3], lvl[3], pend[3];
  int run[3];
  int mw, ms;
  bit eu_w, ed_w, eu_s, ed_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      sh0[b] = 0; sh1[b] = 0; lvl[b] = 0; pend[b] = 0; run[b] = 0;
    end
    mw = 0; ms = 0; eu_w = 0; ed_w = 0; eu_s = 0; ed_s = 0;
  endtask

  task automatic model_step();
    bit rw[3];
    bit s;
    if (rst) begin
      model_reset();
      return;
    end
    eu_w = 0; ed_w = 0; eu_s = 0; ed_s = 0;
    if (pend[2]) begin
      mw = 0; ms = 0;
    end else if (pend[0] && !pend[1]) begin
      mw = (mw + 1) % (MAXV + 1); eu_w = 1;
      if (ms < MAXV) begin ms = ms + 1; eu_s = 1; end
    end else if (pend[1] && !pend[0]) begin
      mw = (mw + MAXV) % (MAXV + 1); ed_w = 1;
      if (ms > 0) begin ms = ms - 1; ed_s = 1; end
    end
    rw[0] = btn_up; rw[1] = btn_down; rw[2] = btn_clr;
    for (int b = 0; b < 3; b++) begin
      s = sh1[b]; sh1[b] = sh0[b]; sh0[b] = rw[b];
      pend[b] = 0;
      if (s == lvl[b]) run[b] = 0;
      else begin
        run[b]++;
        if (run[b] == D) begin
          lvl[b] = s; run[b] = 0; pend[b] = s;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    nup_w += int'(up_evt_w); ndn_w += int'(down_evt_w);
    nup_s += int'(up_evt_s); ndn_s += int'(down_evt_s);
    nup_r += int'(up_evt_r);
    chk("count_w", count_w, mw);
    chk("up_evt_w", up_evt_w, eu_w);
    chk("down_evt_w", down_evt_w, ed_w);
    chk("count_s", count_s, ms);
    chk("up_evt_s", up_evt_s, eu_s);
    chk("down_evt_s", down_evt_s, ed_s);
    chk("at_max_w", at_max_w, mw == MAXV);
    chk("at_min_s", at_min_s, ms == 0);
  endtask

  task automatic set_btn(input int b, input bit v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      default: btn_clr = v;
    endcase
  endtask

  task automatic press(input int b, input int hold, input int gap);
    set_btn(b, 1'b1);
    repeat (hold) cycle();
    set_btn(b, 1'b0);
    repeat (gap) cycle();
  endtask

  initial begin
    int base, n0, n1, n2, n3, pe, exp_total;
    bit exp_evt;
    model_reset();

    // reset state
    repeat (2) cycle();
    chk("rst_count_r", count_r, 0);
    chk("rst_at_min_w", at_min_w, 1);
    rst = 1'b0;

    // clean press: count changes at the 7th edge after raw goes high
    n0 = nup_w;
    btn_up = 1'b1;
    repeat (6) cycle();
    chk("t1_before_latency", count_w, 0);
    cycle();
    chk("t1_at_latency", count_w, 1);
    chk("t1_evt_at_latency", up_evt_w, 1);
    repeat (13) cycle();
    btn_up = 1'b0;
    repeat (10) cycle();
    chk("t1_single_evt", nup_w - n0, 1);

    // bouncing press then glitchy release
    base = mw; n0 = nup_w;
    for (int i = 0; i < 6; i++) begin
      btn_up = (i % 2 == 0);
      cycle();
    end
    chk("t2_no_evt_in_bounce", nup_w - n0, 0);
    btn_up = 1'b1;
    repeat (15) cycle();
    btn_up = 1'b0;
    repeat (2) cycle();
    btn_up = 1'b1;
    repeat (3) cycle();
    btn_up = 1'b0;
    repeat (12) cycle();
    chk("t2_one_evt", nup_w - n0, 1);
    chk("t2_count", count_w, (base + 1) % (MAXV + 1));

    // wrap versus saturate over 20 presses
    press(2, 8, 8);
    chk("t3_clr_w", count_w, 0);
    chk("t3_clr_s", count_s, 0);
    n0 = nup_w; n1 = nup_s;
    for (int i = 0; i < 20; i++) begin
      press(0, 8, 8);
      if (i == 14) begin
        chk("t3_at_max_w", at_max_w, 1);
        chk("t3_w_15", count_w, 15);
      end
      if (i == 15) chk("t3_w_wrapped", count_w, 0);
    end
    chk("t3_sat_count", count_s, 15);
    chk("t3_sat_evts", nup_s - n1, 15);
    chk("t3_wrap_evts", nup_w - n0, 20);
    chk("t3_wrap_count", count_w, 4);
    press(2, 8, 8);
    n0 = ndn_w; n1 = ndn_s;
    press(1, 8, 8);
    chk("t3_sat_no_down", ndn_s - n1, 0);
    chk("t3_sat_at0", count_s, 0);
    chk("t3_wrap_down", ndn_w - n0, 1);
    chk("t3_wrap_under", count_w, 15);

    // simultaneous up+down, then clr+up
    n0 = nup_w; n1 = ndn_w;
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (8) cycle();
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (8) cycle();
    chk("t5_updown_count", count_w, 15);
    chk("t5_updown_no_up", nup_w - n0, 0);
    chk("t5_updown_no_down", ndn_w - n1, 0);
    btn_up = 1'b1; btn_clr = 1'b1;
    repeat (8) cycle();
    btn_up = 1'b0; btn_clr = 1'b0;
    repeat (8) cycle();
    chk("t5_clrup_w", count_w, 0);
    chk("t5_clrup_r", count_r, 0);

    // auto-repeat: raw held for edges 1..40 of this window
    n2 = nup_r; exp_total = 0;
    btn_up = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      if (j == 41) btn_up = 1'b0;
      cycle();
      pe = j - 1;
      exp_evt = (pe == 2 + D) ||
                (pe >= 2 + D + RD && (pe - (2 + D + RD)) % RP == 0 && pe <= 40 + 2);
      exp_total += int'(exp_evt);
      chk("t4_up_evt_r", up_evt_r, exp_evt);
    end
    chk("t4_count_r", count_r, exp_total % (MAXV + 1));
    chk("t4_evt_total_r", nup_r - n2, exp_total);

    // async reset mid-press with count at 7
    press(2, 8, 8);
    for (int i = 0; i < 7; i++) press(0, 8, 8);
    chk("t6_pre_count", count_w, 7);
    btn_up = 1'b1;
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_w", count_w, 0);
    chk("t6_async_s", count_s, 0);
    chk("t6_async_r", count_r, 0);
    model_reset();
    btn_up = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    n0 = nup_w; n3 = nup_r;
    repeat (20) cycle();
    chk("t6_no_phantom_w", nup_w - n0, 0);
    chk("t6_no_phantom_r", nup_r - n3, 0);

    // randomised button activity checked against the reference every cycle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 7) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 15) == 0) btn_clr = ~btn_clr;
      cycle();
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
